// File: rtl/restador_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state enum, default width and counter sizing.
package restador_pkg;

    localparam int WIDTH_DEF = 5;

    function automatic int cnt_width(input int w);
        return $clog2(w + 2);
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/restador_serie_q22_if.sv
// Operand/result handshake bundle for restador_serie_q22.
// The master drives operands and start; the slave returns the result.
interface restador_serie_q22_if #(
    parameter int WIDTH = 5
);

    logic             start;
    logic [WIDTH:0]   c_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             range_err;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output c_in,
        output a_in,
        input  diff,
        input  borrow,
        input  range_err,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  c_in,
        input  a_in,
        output diff,
        output borrow,
        output range_err,
        output busy,
        output done
    );

endinterface

// File: rtl/restador_bit.sv
// Combinational 1-bit full subtractor: d = c - a - bin.
// Used as the single serial bit cell of restador_serie_q22.
module restador_bit (
    input  logic c,
    input  logic a,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = c ^ a ^ bin;
    assign bout = (~c & a) | (~(c ^ a) & bin);

endmodule

// File: rtl/restador_serie_q22.sv
// Bit-serial subtractor, LSB first: diff = c - a over WIDTH+1 bits.
// Define RESTADOR_SAT_EN to clamp diff into 0..2^WIDTH-1.
module restador_serie_q22
    import restador_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    restador_serie_q22_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t state_q;
    state_t state_d;

    logic [WIDTH:0]   c_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    cnt_q;
    logic             bin_q;

    logic [WIDTH:0]   diff_q;
    logic             borrow_q;
    logic             rerr_q;

    logic             d_bit;
    logic             bout_bit;
    logic             last;
    logic [WIDTH:0]   raw;
    logic [WIDTH:0]   res_d;
    logic             rerr_d;

    restador_bit u_bit (
        .c    (c_q[0]),
        .a    (a_q[0]),
        .bin  (bin_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    assign last   = (state_q == RUN) && (cnt_q == CW'(WIDTH));
    assign raw    = {d_bit, r_q};
    assign rerr_d = raw[WIDTH] & ~bout_bit;

    always_comb begin
        res_d = raw;
`ifdef RESTADOR_SAT_EN
        if (bout_bit) begin
            res_d = '0;
        end else if (rerr_d) begin
            res_d = {1'b0, {WIDTH{1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN:  if (last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result bits enter at the top and walk down; bit WIDTH joins at the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q      <= '0;
            a_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else if (state_q == IDLE) begin
            if (bus.start) begin
                c_q   <= bus.c_in;
                a_q   <= {1'b0, bus.a_in};
                r_q   <= '0;
                cnt_q <= '0;
                bin_q <= 1'b0;
            end
        end else if (state_q == RUN) begin
            c_q   <= c_q >> 1;
            a_q   <= a_q >> 1;
            r_q   <= raw[WIDTH:1];
            bin_q <= bout_bit;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
                diff_q   <= res_d;
                borrow_q <= bout_bit;
                rerr_q   <= rerr_d;
            end
        end
    end

    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.range_err = rerr_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);

endmodule

// File: doc/restador_serie_q22.md
Name: restador_serie_q22

Overview:
- Bit-serial subtractor that is the inverse of the team's 5-bit adder: takes a 6-bit sum c and one 5-bit addend a, and recovers b = c - a.
- Processes one bit per clock, LSB first, with a start/busy/done handshake.
- Sits beside the adder in the tile and verifies or round-trips adder results; its operands come from the same ui_in/uio_in pins in the top wrapper.

Parameters:
- WIDTH, 5, addend width; the sum input and the difference are WIDTH+1 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- c_in  input  WIDTH+1  minuend (adder sum); captured when start is accepted.
- a_in  input  WIDTH  subtrahend (known addend), zero-extended; captured when start is accepted.
- diff  output  WIDTH+1  two's-complement result c - a; holds until the next completion.
- borrow  output  1  1 when c < a (final borrow out).
- range_err  output  1  1 when c - a > 2^WIDTH - 1, i.e. b is not representable in WIDTH bits.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - While rst_n = 0: state = IDLE, shift registers = 0, bit counter = 0, borrow chain = 0.
  - All outputs (diff, borrow, range_err, busy, done) read 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on an edge with start = 1, capture c_in and a_in into shift registers, clear the borrow chain and counter, go to RUN. Otherwise stay.
  - RUN: each edge computes one bit, d_i = c_i XOR a_i XOR bin and bout = (~c_i & a_i) | (~(c_i XOR a_i) & bin). Shift operands right; shift d_i into the result MSB; increment the counter.
  - RUN to DONE: after WIDTH+1 bit-edges, on the edge processing bit WIDTH. On that edge, load diff, borrow and range_err, and set done = 1.
  - DONE: lasts exactly one cycle, then returns to IDLE with done = 0.
- Latency:
  - Start accepted at edge k, so done is high between edges k+WIDTH+1 and k+WIDTH+2 (edge k+6 for WIDTH = 5).
  - With start held high continuously, one result every WIDTH+3 cycles.
- Result flags:
  - borrow = final bout.
  - range_err = diff[WIDTH] & ~borrow.
  - diff, borrow and range_err change only on the completion edge.
- Handshake:
  - start is ignored in RUN and DONE; no queuing.
  - c_in and a_in may change freely after capture.
- Boundaries:
  - c = a gives diff 0 with both flags 0.
  - c = 0 and a = 2^WIDTH - 1 gives borrow 1 and diff = -(2^WIDTH - 1) in two's complement.
- Reset mid-operation: rst_n low during RUN or DONE aborts immediately; no done pulse is produced, and the previous result is cleared to 0.

Optional Feature:
- Macro: RESTADOR_SAT_EN.
- Defined: diff is clamped to 0..2^WIDTH-1 with diff[WIDTH] = 0.
  - borrow = 1 gives diff 0.
  - range_err = 1 gives diff 2^WIDTH - 1.
  - Flags are still reported unchanged.
- Undefined: diff is the raw WIDTH+1-bit two's-complement difference.
- Latency is identical in both builds.

Decomposition:
- Shared package restador_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - the default width constant (5);
  - the counter-width localparam, $clog2(WIDTH+2).
- One natural sub-module: restador_bit, a combinational 1-bit full subtractor (inputs c, a, bin; outputs d, bout), instantiated once in the serial datapath.

Test Plan:
- WIDTH = 5, c_in = 45, a_in = 20, start pulse at edge k -> busy high from k; done high exactly after edge k+6; diff = 25, borrow = 0, range_err = 0.
- c_in = 62, a_in = 31 -> diff = 31, flags 0 (maximum adder sum round-trips).
- c_in = 3, a_in = 10 -> borrow = 1, diff = 6'b111001 (-7). With RESTADOR_SAT_EN, diff = 0.
- c_in = 50, a_in = 2 -> diff = 48, range_err = 1, borrow = 0. With RESTADOR_SAT_EN, diff = 31.
- start held high for 24 cycles -> exactly 3 done pulses, 8 cycles apart. A start edge while busy does not restart the operation or change the captured operands.
- rst_n driven low asynchronously mid-RUN (counter = 3) -> busy, done and diff go to 0 without waiting for a clock edge, and no done pulse follows. After release, a start with c = 10, a = 4 gives diff = 6 after 6 edges.
